regfile_sb: RTL and testbench

Parametrised successor to the Y86-64 general-purpose register file used in the DawnCPU pipeline. It adds:
- asynchronous clearing of all registers;
- same-cycle write-to-read bypass;
- deterministic priority when both write ports target one register;
- a per-register pending-write scoreboard, so decode can detect RAW hazards without an external hazard table.

It sits between decode (reads, reservations) and write-back (writes).

---
 rtl/regfile_sb.sv | 121 ++++++++++++
 tb/tb_regfile_sb.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Register file with two write ports, same-cycle write-to-read bypass and a
// per-register pending-write scoreboard for RAW hazard detection in decode.
module regfile_sb #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned NREGS  = 15,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned CNT_W  = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [ID_W-1:0]   srcA_i,
  input  logic [ID_W-1:0]   srcB_i,
  output logic [DATA_W-1:0] valA_o,
  output logic [DATA_W-1:0] valB_o,
  output logic              busyA_o,
  output logic              busyB_o,
  input  logic [ID_W-1:0]   dstA_i,
  input  logic [ID_W-1:0]   dstB_i,
  input  logic [DATA_W-1:0] dstA_data_i,
  input  logic [DATA_W-1:0] dstB_data_i,
  input  logic [ID_W-1:0]   rsvA_i,
  input  logic [ID_W-1:0]   rsvB_i,
  input  logic              flush_i,
  output logic              sb_ovf_o
);

  localparam int unsigned SUM_W   = CNT_W + 2;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic [DATA_W-1:0] r_regs    [NREGS];
  logic [CNT_W-1:0]  r_cnt     [NREGS];
  logic [CNT_W-1:0]  w_cnt_nxt [NREGS];
  logic              r_ovf;
  logic              w_ovf_set;
  logic [1:0]        w_inc;
  logic [1:0]        w_dec;
  logic [SUM_W-1:0]  w_sum;

  logic w_dstA_ok, w_dstB_ok, w_rsvA_ok, w_rsvB_ok;

  // Ids at or above NREGS (including the all-ones "none" id) are inert.
  assign w_dstA_ok = (32'(dstA_i) < NREGS);
  assign w_dstB_ok = (32'(dstB_i) < NREGS);
  assign w_rsvA_ok = (32'(rsvA_i) < NREGS);
  assign w_rsvB_ok = (32'(rsvB_i) < NREGS);

  // Read ports: B write beats A write beats stored value.
  always_comb begin : read_ports
    valA_o  = '0;
    valB_o  = '0;
    busyA_o = 1'b0;
    busyB_o = 1'b0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      if (srcA_i == ID_W'(r)) begin
        valA_o  = r_regs[r];
        busyA_o = |r_cnt[r];
      end
      if (srcB_i == ID_W'(r)) begin
        valB_o  = r_regs[r];
        busyB_o = |r_cnt[r];
      end
    end
    if (w_dstA_ok && (srcA_i == dstA_i)) valA_o = dstA_data_i;
    if (w_dstA_ok && (srcB_i == dstA_i)) valB_o = dstA_data_i;
    if (w_dstB_ok && (srcA_i == dstB_i)) valA_o = dstB_data_i;
    if (w_dstB_ok && (srcB_i == dstB_i)) valB_o = dstB_data_i;
    if (!rst_n_i) begin
      valA_o  = '0;
      valB_o  = '0;
      busyA_o = 1'b0;
      busyB_o = 1'b0;
    end
  end

  // Scoreboard next count: reservations add, writes subtract, result clamped.
  always_comb begin : sb_next
    w_cnt_nxt = '{default: '0};
    w_ovf_set = 1'b0;
    w_inc     = '0;
    w_dec     = '0;
    w_sum     = '0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      w_inc = 2'(w_rsvA_ok && (rsvA_i == ID_W'(r))) + 2'(w_rsvB_ok && (rsvB_i == ID_W'(r)));
      w_dec = 2'(w_dstA_ok && (dstA_i == ID_W'(r))) + 2'(w_dstB_ok && (dstB_i == ID_W'(r)));
      w_sum = SUM_W'(r_cnt[r]) + SUM_W'(w_inc) - SUM_W'(w_dec);
      if (flush_i) begin
        w_cnt_nxt[r] = '0;
      end else if (w_sum[SUM_W-1]) begin
        w_cnt_nxt[r] = '0;
      end else if (w_sum > SUM_W'(CNT_MAX)) begin
        w_cnt_nxt[r] = CNT_W'(CNT_MAX);
        w_ovf_set    = 1'b1;
      end else begin
        w_cnt_nxt[r] = CNT_W'(w_sum);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin : state_regs
    if (!rst_n_i) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        r_regs[r] <= '0;
        r_cnt[r]  <= '0;
      end
      r_ovf <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        if (w_dstB_ok && (dstB_i == ID_W'(r))) begin
          r_regs[r] <= dstB_data_i;
        end else if (w_dstA_ok && (dstA_i == ID_W'(r))) begin
          r_regs[r] <= dstA_data_i;
        end
        r_cnt[r] <= w_cnt_nxt[r];
      end
      r_ovf <= r_ovf | w_ovf_set;
    end
  end

  assign sb_ovf_o = r_ovf;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios then random traffic
// against an integer-count reference model; plus a narrow 32-bit/8-reg build.
module tb_regfile_sb;

  localparam int NR = 15;
  localparam logic [3:0] NONE = 4'hF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  srcA, srcB, dstA, dstB, rsvA, rsvB;
  logic [63:0] dA, dB;
  logic        flush;
  logic [63:0] valA, valB;
  logic        busyA, busyB, ovf;

  logic [3:0]  p_srcA, p_srcB, p_dstA, p_dstB;
  logic [31:0] p_dA, p_dB, p_valA, p_valB;
  logic        p_busyA, p_busyB, p_ovf;

  int n_pass = 0;
  int n_chk  = 0;

  logic [63:0] m_regs [NR];
  int          m_cnt  [NR];
  logic        m_ovf;

  always #5 clk = ~clk;

  regfile_sb u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .srcA_i(srcA), .srcB_i(srcB),
    .valA_o(valA), .valB_o(valB), .busyA_o(busyA), .busyB_o(busyB),
    .dstA_i(dstA), .dstB_i(dstB), .dstA_data_i(dA), .dstB_data_i(dB),
    .rsvA_i(rsvA), .rsvB_i(rsvB), .flush_i(flush), .sb_ovf_o(ovf)
  );

  regfile_sb #(.DATA_W(32), .NREGS(8), .ID_W(4), .CNT_W(2)) u_dut8 (
    .clk_i(clk), .rst_n_i(rst_n), .srcA_i(p_srcA), .srcB_i(p_srcB),
    .valA_o(p_valA), .valB_o(p_valB), .busyA_o(p_busyA), .busyB_o(p_busyB),
    .dstA_i(p_dstA), .dstB_i(p_dstB), .dstA_data_i(p_dA), .dstB_data_i(p_dB),
    .rsvA_i(NONE), .rsvB_i(NONE), .flush_i(1'b0), .sb_ovf_o(p_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic bit ok(input logic [3:0] id);
    return int'(id) < NR;
  endfunction

  function automatic logic [63:0] m_read(input logic [3:0] id);
    if (!ok(id)) return 64'd0;
    if (ok(dstB) && dstB == id) return dB;
    if (ok(dstA) && dstA == id) return dA;
    return m_regs[id];
  endfunction

  function automatic logic m_busy(input logic [3:0] id);
    return ok(id) && (m_cnt[id] != 0);
  endfunction

  task automatic m_reset();
    for (int r = 0; r < NR; r++) begin
      m_regs[r] = '0;
      m_cnt[r]  = 0;
    end
    m_ovf = 1'b0;
  endtask

  // Reference update at a clock edge, from the inputs applied during the cycle.
  task automatic m_clock();
    int n;
    if (ok(dstA)) m_regs[dstA] = dA;
    if (ok(dstB)) m_regs[dstB] = dB;
    for (int r = 0; r < NR; r++) begin
      if (flush) begin
        m_cnt[r] = 0;
      end else begin
        n = m_cnt[r];
        if (ok(rsvA) && int'(rsvA) == r) n++;
        if (ok(rsvB) && int'(rsvB) == r) n++;
        if (ok(dstA) && int'(dstA) == r) n--;
        if (ok(dstB) && int'(dstB) == r) n--;
        if (n < 0) n = 0;
        if (n > 3) begin
          n = 3;
          m_ovf = 1'b1;
        end
        m_cnt[r] = n;
      end
    end
  endtask

  task automatic set_in(input logic [3:0] sa, input logic [3:0] sb,
                        input logic [3:0] da, input logic [63:0] xa,
                        input logic [3:0] db, input logic [63:0] xb,
                        input logic [3:0] ra, input logic [3:0] rb, input logic fl);
    srcA = sa; srcB = sb; dstA = da; dA = xa; dstB = db; dB = xb;
    rsvA = ra; rsvB = rb; flush = fl;
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valA"}, valA, m_read(srcA));
    chk({tag, ".valB"}, valB, m_read(srcB));
    chk({tag, ".busyA"}, 64'(busyA), 64'(m_busy(srcA)));
    chk({tag, ".busyB"}, 64'(busyB), 64'(m_busy(srcB)));
  endtask

  task automatic tick();
    @(posedge clk);
    m_clock();
    #1;
    chk("sb_ovf", 64'(ovf), 64'(m_ovf));
  endtask

  task automatic idle();
    set_in(NONE, NONE, NONE, 64'd0, NONE, 64'd0, NONE, NONE, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    p_srcA = NONE; p_srcB = NONE; p_dstA = NONE; p_dstB = NONE;
    p_dA = '0; p_dB = '0;
    m_reset();
    set_in(4'd3, 4'd0, NONE, 64'd0, NONE, 64'd0, NONE, NONE, 1'b0);
    chk("reset.valA", valA, 64'd0);
    chk("reset.busyA", 64'(busyA), 64'd0);
    chk("reset.ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Write r3 then assert reset mid-cycle: read must drop to 0 without a clock.
    set_in(4'd3, NONE, 4'd3, 64'h1234, NONE, 64'd0, NONE, NONE, 1'b0);
    tick();
    set_in(4'd3, NONE, NONE, 64'd0, NONE, 64'd0, NONE, NONE, 1'b0);
    chk("r3.stored", valA, 64'h1234);
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("async_rst.valA", valA, 64'd0);
    chk("async_rst.busyA", 64'(busyA), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst.r3", valA, 64'd0);

    // None id: reads 0 and writes to it are dropped.
    set_in(NONE, 4'd0, NONE, 64'hDEAD, NONE, 64'd0, NONE, NONE, 1'b0);
    chk("none.valA", valA, 64'd0);
    tick();
    check_all("none.after");

    // Dual write to one register: B wins, also on the bypass.
    set_in(4'd4, 4'd4, 4'd4, 64'hAA, 4'd4, 64'hBB, NONE, NONE, 1'b0);
    chk("dual.bypass", valA, 64'hBB);
    check_all("dual");
    tick();
    set_in(4'd4, NONE, NONE, 64'd0, NONE, 64'd0, NONE, NONE, 1'b0);
    chk("dual.stored", valA, 64'hBB);

    // Reserve r1 at cycle 0, write at cycle 2.
    set_in(4'd1, NONE, NONE, 64'd0, NONE, 64'd0, 4'd1, NONE, 1'b0);
    chk("sb.c0", 64'(busyA), 64'd0);
    tick();
    set_in(4'd1, NONE, NONE, 64'd0, NONE, 64'd0, NONE, NONE, 1'b0);
    chk("sb.c1", 64'(busyA), 64'd1);
    tick();
    set_in(4'd1, NONE, 4'd1, 64'h11, NONE, 64'd0, NONE, NONE, 1'b0);
    chk("sb.c2", 64'(busyA), 64'd1);
    chk("sb.c2.bypass", valA, 64'h11);
    tick();
    set_in(4'd1, NONE, NONE, 64'd0, NONE, 64'd0, NONE, NONE, 1'b0);
    chk("sb.c3", 64'(busyA), 64'd0);

    // Double reserve twice saturates; three writes drain it.
    for (int i = 0; i < 2; i++) begin
      set_in(4'd2, NONE, NONE, 64'd0, NONE, 64'd0, 4'd2, 4'd2, 1'b0);
      tick();
    end
    set_in(4'd2, NONE, NONE, 64'd0, NONE, 64'd0, NONE, NONE, 1'b0);
    chk("sat.ovf", 64'(ovf), 64'd1);
    chk("sat.busy", 64'(busyA), 64'd1);
    chk("sat.cnt", 64'(m_cnt[2]), 64'd3);
    for (int i = 0; i < 3; i++) begin
      set_in(4'd2, NONE, 4'd2, 64'(i), NONE, 64'd0, NONE, NONE, 1'b0);
      chk("drain.busy", 64'(busyA), 64'd1);
      tick();
    end
    set_in(4'd2, NONE, NONE, 64'd0, NONE, 64'd0, NONE, NONE, 1'b0);
    chk("drain.done", 64'(busyA), 64'd0);

    // Flush clears reservations but keeps the concurrent write.
    set_in(4'd5, 4'd6, NONE, 64'd0, NONE, 64'd0, 4'd5, 4'd6, 1'b0);
    tick();
    set_in(4'd5, 4'd6, 4'd5, 64'h77, NONE, 64'd0, 4'd5, 4'd6, 1'b1);
    tick();
    set_in(4'd5, 4'd6, NONE, 64'd0, NONE, 64'd0, NONE, NONE, 1'b0);
    chk("flush.busyA", 64'(busyA), 64'd0);
    chk("flush.busyB", 64'(busyB), 64'd0);
    chk("flush.r5", valA, 64'h77);
    chk("flush.ovf_sticky", 64'(ovf), 64'd1);

    // Narrow build: r7 writes, r9 is out of range.
    p_dstA = 4'd7; p_dA = 32'hDEADBEEF;
    tick();
    p_dstA = 4'd9; p_dA = 32'h55;
    tick();
    p_dstA = NONE; p_srcA = 4'd7; p_srcB = 4'd9;
    #1;
    chk("p8.r7", 64'(p_valA), 64'h0000_0000_DEAD_BEEF);
    chk("p8.r9", 64'(p_valB), 64'd0);
    p_srcB = 4'd1;
    #1;
    chk("p8.r1_no_alias", 64'(p_valB), 64'd0);
    chk("p8.ovf", 64'(p_ovf), 64'd0);
    p_srcA = NONE; p_srcB = NONE;
    idle();

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      set_in(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), {$urandom, $urandom},
             4'($urandom_range(0, 15)), {$urandom, $urandom},
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 15) == 0));
      check_all("rand");
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
